// File: rtl/neo_channel_scheduler.sv
`default_nettype none
// neo_channel_scheduler: round-robin scheduler sharing one NEO datapath across C sample channels.
// Rev 1.0
module neo_channel_scheduler #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int C       = 4,
    parameter int CW      = $clog2(C),
    parameter int TIMEOUT = 64
) (
    input  logic           Clk,
    input  logic           reset,
    input  logic [C*N-1:0] in_data,
    input  logic [C-1:0]   in_valid,
    output logic [C-1:0]   in_ready,
    input  logic [C-1:0]   ch_en,
    output logic           op_start,
    output logic [CW-1:0]  op_ch,
    output logic [N-1:0]   op_x0,
    output logic [N-1:0]   op_x1,
    output logic [N-1:0]   op_x2,
    input  logic           op_done,
    input  logic [M-1:0]   op_result,
    output logic           out_valid,
    output logic [CW-1:0]  out_ch,
    output logic [M-1:0]   out_data,
    output logic           out_err,
    output logic           busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

    state_t        state;
    logic [C-1:0]  pending;
    logic [N-1:0]  sample [C];
    logic [N-1:0]  hist1  [C];
    logic [N-1:0]  hist2  [C];
    logic [1:0]    warm   [C];
    logic [CW-1:0] ptr;
    logic [CW-1:0] gch;
    logic [TW-1:0] tcnt;

    logic [C-1:0]  elig;
    logic          found;
    logic [CW-1:0] gsel;
    logic [CW-1:0] ptr_next;
    int            idx;

    assign in_ready = ch_en & ~pending;
    assign elig     = pending & ch_en;
    assign busy     = (state != S_IDLE);
    assign ptr_next = (gsel == CW'(C - 1)) ? '0 : gsel + CW'(1);

    // First eligible channel at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int i = 0; i < C; i++) begin
            idx = int'(ptr) + i;
            if (idx >= C) idx = idx - C;
            if (!found && elig[idx[CW-1:0]]) begin
                found = 1'b1;
                gsel  = idx[CW-1:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pending   <= '0;
            ptr       <= '0;
            gch       <= '0;
            tcnt      <= '0;
            for (int c = 0; c < C; c++) begin
                sample[c] <= '0;
                hist1[c]  <= '0;
                hist2[c]  <= '0;
                warm[c]   <= '0;
            end
            op_start  <= 1'b0;
            op_ch     <= '0;
            op_x0     <= '0;
            op_x1     <= '0;
            op_x2     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            op_start  <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;

            // The channel in service is exempt from disable-clearing until it finishes.
            for (int c = 0; c < C; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    sample[c]  <= in_data[c*N +: N];
                    pending[c] <= 1'b1;
                end
                if (!ch_en[c] && !((state != S_IDLE) && (gch == CW'(c)))) begin
                    pending[c] <= 1'b0;
                    warm[c]    <= '0;
                    hist1[c]   <= '0;
                    hist2[c]   <= '0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (found) begin
                        gch <= gsel;
                        ptr <= ptr_next;
                        if (warm[gsel] == 2'd2) begin
                            state    <= S_ISSUE;
                            op_start <= 1'b1;
                            op_ch    <= gsel;
                            op_x0    <= sample[gsel];
                            op_x1    <= hist1[gsel];
                            op_x2    <= hist2[gsel];
                        end else begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    tcnt  <= '0;
                end
                S_WAIT: begin
                    if (op_done) begin
                        state     <= S_WRITE;
                        out_valid <= 1'b1;
                        out_ch    <= gch;
                        out_data  <= op_result;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state     <= S_WRITE;
                        out_valid <= 1'b1;
                        out_ch    <= gch;
                        out_data  <= '0;
                        out_err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    hist2[gch]   <= hist1[gch];
                    hist1[gch]   <= sample[gch];
                    pending[gch] <= 1'b0;
                    warm[gch]    <= (warm[gch] == 2'd2) ? 2'd2 : warm[gch] + 2'd1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
